// File: rtl/rtc_disp_ctrl_pkg.sv
// Shared types, constants and frame helpers for the RTC display controller.
// The controller walks six 7-segment digits, each digit packed as one byte of a 48-bit frame.
package rtc_disp_pkg;

  typedef enum logic [1:0] {
    LIVE     = 2'd0,
    LAP_HOLD = 2'd1,
    EDIT     = 2'd2
  } disp_mode_e;

  localparam int         NUM_DIGITS = 6;
  localparam int         SEG_W      = 8;
  localparam int         FRAME_W    = NUM_DIGITS * SEG_W;
  localparam logic [7:0] SEG_BLANK  = 8'hFF;

  function automatic logic [7:0] digit_onehot(input logic [2:0] idx);
    logic [7:0] oh;
    oh = 8'h00;
    if (idx < 3'd6) begin
      oh[idx] = 1'b1;
    end else begin
      oh = 8'h00;
    end
    return oh;
  endfunction

  function automatic logic [7:0] frame_digit(input logic [47:0] frame, input logic [2:0] idx);
    logic [7:0] seg;
    if (idx < 3'd6) begin
      seg = frame[{idx, 3'b000} +: SEG_W];
    end else begin
      seg = SEG_BLANK;
    end
    return seg;
  endfunction

endpackage

// File: rtl/rtc_disp_ctrl_if.sv
// Lap snapshot request/acknowledge channel between the stopwatch core and the display controller.
// Signal names are from the controller's point of view.
interface rtc_disp_ctrl_if;
  logic [47:0] i_lap_segs;
  logic        i_lap_req;
  logic        i_lap_clr;
  logic        o_lap_ack;

  modport master (output i_lap_segs, output i_lap_req, output i_lap_clr, input o_lap_ack);
  modport slave  (input i_lap_segs, input i_lap_req, input i_lap_clr, output o_lap_ack);
endinterface

// File: rtl/rtc_tick_gen.sv
// Generic prescaler: counts 0..DIV-1 while enabled and flags the terminal-count cycle.
// clr restarts the period.
module rtc_tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // next count: clear wins, otherwise wrap at terminal count
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == TERM) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // counter register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && !clr && (cnt_q == TERM);

endmodule

// File: rtl/rtc_disp_ctrl.sv
// Display scheduler for the 6-digit scan path: picks live or lap frame, scans digits every
// CLK_HZ/SCAN_HZ cycles and blinks the edited digit. All outputs come straight from flops.
module rtc_disp_ctrl
  import rtc_disp_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int SCAN_HZ     = 1_000,
  parameter int BLINK_HZ    = 2,
  parameter int LAP_HOLD_MS = 3_000
) (
  input  logic                  i_sys_clk,
  input  logic                  i_reset_n,
  input  logic [47:0]           i_live_segs,
  rtc_disp_ctrl_if.slave        lap,
  input  logic                  i_edit_en,
  input  logic [2:0]            i_edit_digit,
  output logic                  o_scan_tick,
  output logic [1:0]            o_mode,
  output logic [7:0]            o_segments,
  output logic [7:0]            o_digits
);

  localparam int SCAN_DIV   = CLK_HZ / SCAN_HZ;
  localparam int BLINK_DIV  = CLK_HZ / (2 * BLINK_HZ);
  localparam int HOLD_TICKS = (LAP_HOLD_MS * SCAN_HZ) / 1000;
  localparam int HW         = $clog2(HOLD_TICKS + 1);

  disp_mode_e   mode_q,     mode_d;
  logic [2:0]   idx_q,      idx_d;
  logic [HW-1:0] hold_q,    hold_d;
  logic [47:0]  snap_q,     snap_d;
  logic         blink_on_q, blink_on_d;
  logic         ack_q,      ack_d;
  logic         tick_q,     tick_d;
  logic [7:0]   seg_q,      seg_d;
  logic [7:0]   dig_q,      dig_d;

  logic         scan_tick;
  logic         blink_tick;
  logic         blink_clr;
  logic         blink_en;
  logic [47:0]  src_frame;

  assign blink_clr = i_edit_en && (mode_q != EDIT);
  assign blink_en  = (mode_q == EDIT);

  rtc_tick_gen #(.DIV(SCAN_DIV)) u_scan_tick (
    .clk   (i_sys_clk),
    .rst_n (i_reset_n),
    .en    (1'b1),
    .clr   (1'b0),
    .tick  (scan_tick)
  );

  rtc_tick_gen #(.DIV(BLINK_DIV)) u_blink_tick (
    .clk   (i_sys_clk),
    .rst_n (i_reset_n),
    .en    (blink_en),
    .clr   (blink_clr),
    .tick  (blink_tick)
  );

  // mode transitions, hold timer, snapshot capture and blink phase
  always_comb begin
    mode_d     = mode_q;
    hold_d     = hold_q;
    snap_d     = snap_q;
    blink_on_d = blink_on_q;
    ack_d      = 1'b0;
    if (i_edit_en) begin
      mode_d = EDIT;
      if (mode_q != EDIT) begin
        blink_on_d = 1'b1;
      end else if (blink_tick) begin
        blink_on_d = ~blink_on_q;
      end else begin
        blink_on_d = blink_on_q;
      end
    end else begin
      case (mode_q)
        LIVE: begin
          if (lap.i_lap_req) begin
            mode_d = LAP_HOLD;
            snap_d = lap.i_lap_segs;
            hold_d = HW'(HOLD_TICKS);
            ack_d  = 1'b1;
          end else begin
            mode_d = LIVE;
          end
        end
        LAP_HOLD: begin
          // a fresh request restarts the hold even if a clear arrives with it
          if (lap.i_lap_req) begin
            snap_d = lap.i_lap_segs;
            hold_d = HW'(HOLD_TICKS);
            ack_d  = 1'b1;
          end else if (lap.i_lap_clr) begin
            mode_d = LIVE;
          end else if (scan_tick) begin
            if (hold_q <= HW'(1)) begin
              mode_d = LIVE;
              hold_d = '0;
            end else begin
              hold_d = hold_q - HW'(1);
            end
          end else begin
            mode_d = LAP_HOLD;
          end
        end
        EDIT: begin
          mode_d = LIVE;
        end
        default: begin
          mode_d = LIVE;
        end
      endcase
    end
  end

  // scan index and the registered digit/segment outputs
  always_comb begin
    idx_d = idx_q;
    if (scan_tick) begin
      if (idx_q == 3'd5) begin
        idx_d = 3'd0;
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end else begin
      idx_d = idx_q;
    end

    if (mode_q == LAP_HOLD) begin
      src_frame = snap_q;
    end else begin
      src_frame = i_live_segs;
    end

    seg_d = frame_digit(src_frame, idx_q);
    if ((mode_q == EDIT) && !blink_on_q && (i_edit_digit == idx_q)) begin
      seg_d = SEG_BLANK;
    end else begin
      seg_d = frame_digit(src_frame, idx_q);
    end
    dig_d  = digit_onehot(idx_q);
    tick_d = scan_tick;
  end

  // state and output registers, synchronous active-low reset
  always_ff @(posedge i_sys_clk) begin
    if (!i_reset_n) begin
      mode_q     <= LIVE;
      idx_q      <= 3'd0;
      hold_q     <= '0;
      snap_q     <= 48'h0;
      blink_on_q <= 1'b1;
      ack_q      <= 1'b0;
      tick_q     <= 1'b0;
      seg_q      <= 8'h00;
      dig_q      <= 8'h00;
    end else begin
      mode_q     <= mode_d;
      idx_q      <= idx_d;
      hold_q     <= hold_d;
      snap_q     <= snap_d;
      blink_on_q <= blink_on_d;
      ack_q      <= ack_d;
      tick_q     <= tick_d;
      seg_q      <= seg_d;
      dig_q      <= dig_d;
    end
  end

  assign lap.o_lap_ack = ack_q;
  assign o_scan_tick   = tick_q;
  assign o_mode        = mode_q;
  assign o_segments    = seg_q;
  assign o_digits      = dig_q;

endmodule
